// File: rtl/truth_table_sweeper_pkg.sv
// Shared constants and state encoding for the truth-table sweeper and its settle timer.
package truth_table_sweeper_pkg;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned NUM_ROWS = 8;
  localparam int unsigned CNT_W    = 8;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StSettle = 2'd1;
  localparam state_t StDone   = 2'd2;

endpackage

// File: rtl/truth_table_sweeper_settle.sv
// Per-combination settle counter: counts 0..SETTLE_CYCLES-1 and flags the terminal count.
module sweep_settle_timer
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic last_o
);

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign last_o = (cnt_q == TermCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight input combinations into a 3-input gate, captures its truth table and
// compares it against EXPECTED.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'hDF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       gate_out_i,
  output logic       in1_o,
  output logic       in2_o,
  output logic       in3_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] table_o,
  output logic [7:0] mismatch_o,
  output logic       pass_o
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_ROWS-1:0] table_q, table_d;
  logic [7:0]         mismatch_q, mismatch_d;
  logic               pass_q, pass_d;
  logic               busy_q, done_q;
  logic               last;
  logic               in_settle;

  assign in_settle = (state_q == StSettle);

  sweep_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (!in_settle || abort_i),
    .enable_i(in_settle),
    .last_o  (last)
  );

  // idx_q doubles as the gate input drive, so it is zeroed whenever the sweep is not running.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    table_d    = table_q;
    mismatch_d = mismatch_q;
    pass_d     = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !abort_i) begin
          state_d = StSettle;
          idx_d   = '0;
          table_d = '0;
        end
      end
      StSettle: begin
        if (abort_i) begin
          state_d    = StIdle;
          idx_d      = '0;
          table_d    = '0;
          mismatch_d = '0;
          pass_d     = 1'b0;
        end else if (last) begin
          table_d[idx_q] = gate_out_i;
          if (idx_q == IDX_W'(NUM_ROWS - 1)) begin
            state_d    = StDone;
            idx_d      = '0;
            mismatch_d = table_d ^ EXPECTED;
            pass_d     = (table_d == EXPECTED);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      table_q    <= '0;
      mismatch_q <= '0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      table_q    <= table_d;
      mismatch_q <= mismatch_d;
      pass_q     <= pass_d;
      busy_q     <= (state_d == StSettle);
      done_q     <= (state_d == StDone);
    end
  end

  assign {in1_o, in2_o, in3_o} = idx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign table_o    = table_q;
  assign mismatch_o = mismatch_q;
  assign pass_o     = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: unit 0 uses default parameters, unit 1 SETTLE_CYCLES=1.
module tb_truth_table_sweeper;

  typedef struct {
    logic [7:0] tbl;
    logic [7:0] mm;
    logic       ps;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start_s, abort_s, gate_s;
  logic [1:0]  in1_s, in2_s, in3_s, busy_s, done_s, pass_s;
  logic [15:0] tbl_s, mm_s;
  logic [15:0] tt_s;
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Behavioural gate models, one per unit.
  assign gate_s[0] = tt_s[{1'b0, in1_s[0], in2_s[0], in3_s[0]}];
  assign gate_s[1] = tt_s[{1'b1, in1_s[1], in2_s[1], in3_s[1]}];

  truth_table_sweeper u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .abort_i(abort_s[0]),
    .gate_out_i(gate_s[0]), .in1_o(in1_s[0]), .in2_o(in2_s[0]), .in3_o(in3_s[0]),
    .busy_o(busy_s[0]), .done_o(done_s[0]), .table_o(tbl_s[7:0]),
    .mismatch_o(mm_s[7:0]), .pass_o(pass_s[0])
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'hDF)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .abort_i(abort_s[1]),
    .gate_out_i(gate_s[1]), .in1_o(in1_s[1]), .in2_o(in2_s[1]), .in3_o(in3_s[1]),
    .busy_o(busy_s[1]), .done_o(done_s[1]), .table_o(tbl_s[15:8]),
    .mismatch_o(mm_s[15:8]), .pass_o(pass_s[1])
  );

  task automatic test_reset();
    rst = 1'b1; start_s = '0; abort_s = '0; tt_s = {8'hDF, 8'hDF};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int u = 0; u < 2; u++) begin
      total++;
      if ({busy_s[u], done_s[u], pass_s[u], in1_s[u], in2_s[u], in3_s[u],
           tbl_s[u*8 +: 8], mm_s[u*8 +: 8]} !== 22'd0) begin
        bad++;
        $display("FAIL reset u%0d: busy=%b done=%b pass=%b in=%b%b%b table=%h mm=%h want all 0",
                 u, busy_s[u], done_s[u], pass_s[u], in1_s[u], in2_s[u], in3_s[u],
                 tbl_s[u*8 +: 8], mm_s[u*8 +: 8]);
      end
    end
  endtask

  // Full sweep on unit u; poke pulses start during busy and in the DONE cycle.
  task automatic test_sweep(input int u, input int settle, input logic [7:0] tt,
                            input logic [7:0] expc, input bit poke);
    int   cyc;
    int   last_busy;
    logic exp_busy;
    logic [2:0] exp_idx;
    exp_t e;
    tt_s[u*8 +: 8] = tt;
    sb.push_back('{tbl: tt, mm: tt ^ expc, ps: (tt == expc), cyc: 8 * settle + 1});
    start_s[u] = 1'b1;
    @(negedge clk);
    start_s[u] = 1'b0;
    last_busy = 8 * settle;
    for (cyc = 1; cyc <= last_busy + 4; cyc++) begin
      exp_busy = (cyc <= last_busy);
      exp_idx  = exp_busy ? 3'((cyc - 1) / settle) : 3'd0;
      total++;
      if (busy_s[u] !== exp_busy) begin
        bad++;
        $display("FAIL busy u%0d cyc%0d: got %b want %b", u, cyc, busy_s[u], exp_busy);
      end
      total++;
      if ({in1_s[u], in2_s[u], in3_s[u]} !== exp_idx) begin
        bad++;
        $display("FAIL inputs u%0d cyc%0d: got %b%b%b want %b", u, cyc,
                 in1_s[u], in2_s[u], in3_s[u], exp_idx);
      end
      total++;
      if (done_s[u] !== (cyc == last_busy + 1)) begin
        bad++;
        $display("FAIL done u%0d cyc%0d: got %b want %b", u, cyc, done_s[u],
                 cyc == last_busy + 1);
      end
      if (done_s[u] === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL done_cycle u%0d: got %0d want %0d", u, cyc, e.cyc);
        end
        total++;
        if (tbl_s[u*8 +: 8] !== e.tbl || mm_s[u*8 +: 8] !== e.mm || pass_s[u] !== e.ps) begin
          bad++;
          $display("FAIL result u%0d: table=%h mm=%h pass=%b want table=%h mm=%h pass=%b", u,
                   tbl_s[u*8 +: 8], mm_s[u*8 +: 8], pass_s[u], e.tbl, e.mm, e.ps);
        end
      end
      start_s[u] = poke && (cyc == 3 || cyc == last_busy + 1);
      @(negedge clk);
    end
    start_s[u] = 1'b0;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL no_done u%0d: %0d results outstanding want 0", u, sb.size());
      sb.delete();
    end
    total++;
    if (tbl_s[u*8 +: 8] !== tt) begin
      bad++;
      $display("FAIL table_hold u%0d: got %h want %h", u, tbl_s[u*8 +: 8], tt);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    tt_s[7:0] = 8'hDF;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    abort_s[0] = 1'b1;           // present during the edge ending cycle 5
    @(negedge clk);
    abort_s[0] = 1'b0;
    total++;
    if ({busy_s[0], in1_s[0], in2_s[0], in3_s[0], tbl_s[7:0], pass_s[0], mm_s[7:0]} !== 21'd0) begin
      bad++;
      $display("FAIL abort: busy=%b in=%b%b%b table=%h pass=%b mm=%h want all 0", busy_s[0],
               in1_s[0], in2_s[0], in3_s[0], tbl_s[7:0], pass_s[0], mm_s[7:0]);
    end
    for (int i = 0; i < 20; i++) begin
      if (done_s[0] === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones != 0) begin
      bad++;
      $display("FAIL abort_done: got %0d done pulses want 0", dones);
    end
  endtask

  task automatic test_reset_mid();
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (8) @(negedge clk);   // now in cycle 9, idx 4
    total++;
    if ({in1_s[0], in2_s[0], in3_s[0]} !== 3'd4) begin
      bad++;
      $display("FAIL pre_reset_idx: got %b%b%b want 100", in1_s[0], in2_s[0], in3_s[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy_s[0], done_s[0], pass_s[0], in1_s[0], in2_s[0], in3_s[0], tbl_s[7:0],
         mm_s[7:0]} !== 22'd0) begin
      bad++;
      $display("FAIL mid_reset: busy=%b done=%b pass=%b in=%b%b%b table=%h mm=%h want all 0",
               busy_s[0], done_s[0], pass_s[0], in1_s[0], in2_s[0], in3_s[0], tbl_s[7:0],
               mm_s[7:0]);
    end
  endtask

  task automatic test_start_abort_idle();
    int busies = 0;
    start_s[0] = 1'b1;
    abort_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    abort_s[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy_s[0] === 1'b1 || done_s[0] === 1'b1) busies++;
      @(negedge clk);
    end
    total++;
    if (busies != 0) begin
      bad++;
      $display("FAIL start_abort_idle: got %0d active cycles want 0", busies);
    end
  endtask

  initial begin
    test_reset();
    test_sweep(0, 2, 8'hDF, 8'hDF, 1'b0);
    test_sweep(0, 2, 8'hDE, 8'hDF, 1'b0);
    test_sweep(1, 1, 8'hDF, 8'hDF, 1'b0);
    test_abort();
    test_sweep(0, 2, 8'hDF, 8'hDF, 1'b0);
    test_sweep(0, 2, 8'h5A, 8'hDF, 1'b1);
    test_sweep(1, 1, 8'h01, 8'hDF, 1'b1);
    test_reset_mid();
    test_start_abort_idle();
    test_sweep(0, 2, 8'hDF, 8'hDF, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
